// File: rtl/regbank_arbiter.sv
// regbank_arbiter: two-master arbiter serialising single-word transactions onto one register-bank port
module regbank_arbiter #(
  parameter int p_WIDTH_ADDR = 16,
  parameter int p_WIDTH_DATA = 16,
  parameter int p_FIXED_PRIO = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    m0_req,
  input  logic                    m0_we,
  input  logic [p_WIDTH_ADDR-1:0] m0_addr,
  input  logic [p_WIDTH_DATA-1:0] m0_wdata,
  output logic                    m0_ack,
  output logic [p_WIDTH_DATA-1:0] m0_rdata,
  input  logic                    m1_req,
  input  logic                    m1_we,
  input  logic [p_WIDTH_ADDR-1:0] m1_addr,
  input  logic [p_WIDTH_DATA-1:0] m1_wdata,
  output logic                    m1_ack,
  output logic [p_WIDTH_DATA-1:0] m1_rdata,
  output logic [p_WIDTH_ADDR-1:0] bank_addr,
  output logic [p_WIDTH_DATA-1:0] bank_wdata,
  output logic                    bank_wen,
  output logic                    bank_ren,
  input  logic [p_WIDTH_DATA-1:0] bank_rdata,
  output logic                    busy,
  output logic                    grant
);
  typedef enum logic [2:0] {IDLE, WR, RD1, RD2, DONE} state_t;
  state_t state_q, state_d;
  logic grant_q, grant_d, rr_q, rr_d, win;
  logic [p_WIDTH_ADDR-1:0] bank_addr_q, bank_addr_d;
  logic [p_WIDTH_DATA-1:0] bank_wdata_q, bank_wdata_d, m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  // rr_q names the master preferred on a tie; it points away from the last grant
  assign win = (m0_req && m1_req) ? ((p_FIXED_PRIO != 0) ? 1'b0 : rr_q) : m1_req;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d = rr_q;
    bank_addr_d = bank_addr_q;
    bank_wdata_d = bank_wdata_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    case (state_q)
      IDLE: if (m0_req || m1_req) begin
        grant_d = win;
        bank_addr_d = win ? m1_addr : m0_addr;
        bank_wdata_d = win ? m1_wdata : m0_wdata;
        state_d = (win ? m1_we : m0_we) ? WR : RD1;
      end
      WR: state_d = DONE;
      RD1: state_d = RD2;
      RD2: begin
        state_d = DONE;
        m0_rdata_d = grant_q ? m0_rdata_q : bank_rdata;
        m1_rdata_d = grant_q ? bank_rdata : m1_rdata_q;
      end
      DONE: begin
        state_d = IDLE;
        rr_d = ~grant_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      rr_q <= 1'b0;
      bank_addr_q <= '0;
      bank_wdata_q <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q <= rr_d;
      bank_addr_q <= bank_addr_d;
      bank_wdata_q <= bank_wdata_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end
  assign bank_addr = bank_addr_q;
  assign bank_wdata = bank_wdata_q;
  assign bank_wen = state_q == WR;
  assign bank_ren = state_q == RD1;
  assign m0_ack = state_q == DONE && !grant_q;
  assign m1_ack = state_q == DONE && grant_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign busy = state_q != IDLE;
  assign grant = grant_q;
endmodule

// File: doc/regbank_arbiter.md
Name: regbank_arbiter

Overview:
- Two-master arbiter in front of the shared register bank (sum/num1-3/ctrl, FIFO port at 0x0005, RAM window 0x0100-0x01FF).
- Master 0 is the FSMC bus bridge; master 1 is the SPI slave bridge.
- Serialises their single-word transactions onto one wen/ren/addr/wdata port.
- Sequences the bank's one-cycle-delayed read, holding the address stable until read data is captured, and returns per-master ack and read data.

Parameters:
- p_WIDTH_ADDR, 16, address width of masters and bank port
- p_WIDTH_DATA, 16, data width
- p_FIXED_PRIO, 0, 0 = round-robin between masters; 1 = master 0 always wins a tie

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- m0_req  in  1  master 0 transaction request, level
- m0_we  in  1  master 0 direction, 1 = write, 0 = read
- m0_addr  in  p_WIDTH_ADDR  master 0 address
- m0_wdata  in  p_WIDTH_DATA  master 0 write data
- m0_ack  out  1  master 0 completion pulse, one cycle
- m0_rdata  out  p_WIDTH_DATA  master 0 read data, valid while m0_ack=1, held until next m0 read completes
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  same as master 0, for master 1
- bank_addr  out  p_WIDTH_ADDR  address to register bank
- bank_wdata  out  p_WIDTH_DATA  write data to register bank
- bank_wen  out  1  write enable to register bank
- bank_ren  out  1  read enable to register bank
- bank_rdata  in  p_WIDTH_DATA  bank read data, valid in the cycle after bank_ren while bank_addr is held
- busy  out  1  high in every state except IDLE
- grant  out  1  index of the master owning the current or last transaction

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE. All outputs 0: bank_addr, bank_wdata, bank_wen, bank_ren, m0/m1_ack, m0/m1_rdata, busy, grant. Round-robin pointer selects master 0 first.
- Reset mid-transaction: abort immediately; no ack is issued; the aborted master must re-request.
- Masters hold req/we/addr/wdata stable from assertion until they see ack. The master drops req, or presents a new transaction, on the edge ending the ack cycle.
- FSM states: IDLE, WR, RD1, RD2, DONE.
- IDLE: on an edge with any req=1, arbitrate:
  - Only one master requesting: that master wins.
  - Both requesting, p_FIXED_PRIO=1: master 0 wins.
  - Both requesting, p_FIXED_PRIO=0: the master not granted last wins.
  - On the winning edge: set grant; register bank_addr/bank_wdata from the winner; go to WR if we=1, else RD1.
- WR: bank_wen=1 for exactly one cycle. Next state DONE.
- RD1: bank_ren=1 for exactly one cycle; bank_addr held. Next state RD2.
- RD2: bank_ren=0; bank_addr still held. At the edge, capture bank_rdata into mX_rdata of the granted master. Next state DONE.
- DONE: ack of the granted master =1 for exactly one cycle; bank_wen=bank_ren=0. Next state IDLE; the round-robin pointer advances past the granted master.
- Latency from req seen in IDLE:
  - Write: ack in the 3rd cycle (IDLE, WR, DONE).
  - Read: ack in the 4th cycle (IDLE, RD1, RD2, DONE).
  - Minimum issue interval per transaction: 3 cycles for writes, 4 for reads.
- After a transaction, bank_addr and bank_wdata hold their last values; bank_wen and bank_ren stay 0 outside WR/RD1. This keeps single-pulse semantics for the bank's FIFO pop/push and RAM write request.
- The losing master's request stays pending and is served in the next arbitration. With both masters continuously requesting in round-robin mode, grants strictly alternate; no starvation.
- A req deasserted while waiting (not yet granted) is protocol-illegal. If it drops before the IDLE sampling edge, it is simply not served.
- The non-granted master's ack and rdata are unaffected by the other master's transaction.
- No address decoding: addresses pass through unchanged, including unmapped ones. An unmapped read returns whatever the bank returns (0).

Test Plan:
- m0 write 0x0001←0x1234, then m0 read 0x0001 -> bank_wen pulses one cycle with addr 0x0001; read ack 4 cycles after req with m0_rdata=0x1234; bank_ren high exactly one cycle.
- m0 and m1 raise req on the same edge, round-robin, reset state; m0 writes 0x0002←0x0005, m1 reads 0x0000 -> m0 served first (ack cycle 3), then m1 (ack 4 cycles later). m1_rdata equals the bank's sum value; grant sequence 0,1.
- Both masters reading 0x0005 (FIFO) back-to-back for 8 transactions, p_FIXED_PRIO=0 -> grants alternate 0,1,0,1…; bank_ren is never high two consecutive cycles; exactly 8 FIFO pops.
- p_FIXED_PRIO=1, both requesting continuously -> master 0 granted every arbitration; m1 served only after m0 drops req.
- RAM window: m1 writes 0x01FF←0xBEEF, then m0 reads 0x01FF -> m0_rdata=0xBEEF. bank_addr is held at 0x01FF through RD1 and RD2.
- rst_n=0 during RD2 of an m1 read -> next cycle state IDLE; m1_ack never pulses; all outputs 0. m1 re-requests and completes normally, and m0 has round-robin priority.
